llc_update_fifo: RTL

Buffers update packets between the LLC process stage and the update stage. The process stage pushes one `fifo_proc_update_packet` per retired request through a valid/ready handshake. The block stores packets in a circular buffer and presents the head entry to the update stage as `fifo_update_out` / `fifo_empty_update`, with `fifo_pop_update` as the dequeue strobe. It also maintains the "in pipeline" flags for reset/flush resume and a mask of set-table pointers whose removal is still pending.

---
 rtl/llc_update_fifo_pkg.sv | 17 +
 rtl/llc_update_fifo_if.sv | 22 ++
 rtl/llc_fifo_ptr_ctrl.sv | 56 +++++
 rtl/llc_update_fifo.sv | 131 +++++++++++++
 4 files changed

// File: rtl/llc_update_fifo_pkg.sv
// Shared types and constants for the LLC process-to-update FIFO.
// Holds the update packet layout, the default FIFO depth and the set-table size.
package llc_update_fifo_pkg;

  localparam int LLC_UPDATE_FIFO_DEPTH = 4;
  localparam int LLC_SET_TABLE_ENTRIES = 8;
  localparam int TPTR_W                = $clog2(LLC_SET_TABLE_ENTRIES);

  typedef struct packed {
    logic [15:0]       addr;
    logic [2:0]        cpu_msg;
    logic              is_rst_to_resume;
    logic              is_flush_to_resume;
    logic [TPTR_W-1:0] table_pointer_to_remove;
  } fifo_proc_update_packet;

endpackage

// File: rtl/llc_update_fifo_if.sv
// Process-stage push handshake and update-stage head/pop signals of the LLC update FIFO.
interface llc_update_fifo_if;
  import llc_update_fifo_pkg::*;

  logic                   proc_valid;
  fifo_proc_update_packet proc_packet;
  logic                   proc_ready;
  logic                   fifo_pop_update;
  fifo_proc_update_packet fifo_update_out;
  logic                   fifo_empty_update;

  modport master (
    output proc_valid, proc_packet, fifo_pop_update,
    input  proc_ready, fifo_update_out, fifo_empty_update
  );

  modport slave (
    input  proc_valid, proc_packet, fifo_pop_update,
    output proc_ready, fifo_update_out, fifo_empty_update
  );

endinterface

// File: rtl/llc_fifo_ptr_ctrl.sv
// Read/write pointers, occupancy and full/empty state for a power-of-two circular buffer.
// push and pop arrive already qualified by the caller.
module llc_fifo_ptr_ctrl #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_next_s;
  logic          full_r, empty_r;

  // Next occupancy from the qualified push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push, pop})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointer, count and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
      empty_r <= (count_next_s == CW'(0));
    end
  end

  assign wr_ptr = wr_ptr_r;
  assign rd_ptr = rd_ptr_r;
  assign count  = count_r;
  assign full   = full_r;
  assign empty  = empty_r;

endmodule

// File: rtl/llc_update_fifo.sv
// Circular buffer of update packets between the LLC process and update stages, with
// in-pipeline resume flags and a pending set-table mask. Optional: LLC_UPDATE_FIFO_BYPASS_EN.
module llc_update_fifo
  import llc_update_fifo_pkg::*;
#(
  parameter int DEPTH       = LLC_UPDATE_FIFO_DEPTH,
  parameter int PTR_ENTRIES = LLC_SET_TABLE_ENTRIES
) (
  input  logic                     clk,
  input  logic                     rst,
  llc_update_fifo_if.slave         bus,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  input  logic                     clr_rst_to_resume_in_pipeline_update,
  input  logic                     clr_flush_to_resume_in_pipeline_update,
  output logic                     rst_to_resume_in_pipeline,
  output logic                     flush_to_resume_in_pipeline,
  output logic [PTR_ENTRIES-1:0]   pending_table_mask
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]          wr_ptr_s, rd_ptr_s;
  logic [AW:0]            count_s;
  logic                   full_s, empty_s;
  logic                   push_s, pop_s, store_push_s, store_pop_s;
  fifo_proc_update_packet mem_r [DEPTH];
  logic [PTR_ENTRIES-1:0] mask_r, set_vec_s, clr_vec_s, mask_next_s;
  logic                   rst_flag_r, flush_flag_r;

  assign push_s      = bus.proc_valid && !full_s;
  assign pop_s       = bus.fifo_pop_update && !bus.fifo_empty_update;
  assign store_pop_s = bus.fifo_pop_update && !empty_s;

`ifdef LLC_UPDATE_FIFO_BYPASS_EN
  logic              byp_s;
  logic              byp_clr_v_r;
  logic [TPTR_W-1:0] byp_clr_ptr_r;

  // An offer into an empty FIFO is visible at the head; if popped at once it is never stored.
  assign byp_s                 = empty_s && bus.proc_valid;
  assign bus.fifo_empty_update = empty_s && !bus.proc_valid;
  assign store_push_s          = push_s && !(byp_s && bus.fifo_pop_update);

  // A consumed bypass packet leaves its mask bit set for one cycle; remember it to clear next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byp_clr_v_r   <= 1'b0;
      byp_clr_ptr_r <= '0;
    end else begin
      byp_clr_v_r   <= byp_s && bus.fifo_pop_update;
      byp_clr_ptr_r <= bus.proc_packet.table_pointer_to_remove;
    end
  end
`else
  assign bus.fifo_empty_update = empty_s;
  assign store_push_s          = push_s;
`endif

  assign bus.proc_ready = !full_s;
  assign fifo_full      = full_s;
  assign fifo_count     = count_s;

  llc_fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk    (clk),
    .rst    (rst),
    .push   (store_push_s),
    .pop    (store_pop_s),
    .wr_ptr (wr_ptr_s),
    .rd_ptr (rd_ptr_s),
    .count  (count_s),
    .full   (full_s),
    .empty  (empty_s)
  );

  // Packet storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (store_push_s) mem_r[wr_ptr_s] <= bus.proc_packet;
  end

  // Head presentation; all-zero when nothing is available so no request is decoded.
  always_comb begin
    bus.fifo_update_out = '0;
    if (!empty_s) begin
      bus.fifo_update_out = mem_r[rd_ptr_s];
    end
`ifdef LLC_UPDATE_FIFO_BYPASS_EN
    else if (bus.proc_valid) begin
      bus.fifo_update_out = bus.proc_packet;
    end
`endif
    else begin
      bus.fifo_update_out = '0;
    end
  end

  // Pending-mask next state: clear on pop, set on push, set wins on the same pointer.
  always_comb begin
    set_vec_s = '0;
    clr_vec_s = '0;
    if (push_s) set_vec_s[bus.proc_packet.table_pointer_to_remove] = 1'b1;
    else        set_vec_s = '0;
    if (pop_s)  clr_vec_s[bus.fifo_update_out.table_pointer_to_remove] = 1'b1;
    else        clr_vec_s = '0;
`ifdef LLC_UPDATE_FIFO_BYPASS_EN
    if (byp_clr_v_r) clr_vec_s[byp_clr_ptr_r] = 1'b1;
    else             clr_vec_s = clr_vec_s;
`endif
    mask_next_s = (mask_r & ~clr_vec_s) | set_vec_s;
  end

  // Resume flags and pending mask registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_flag_r   <= 1'b0;
      flush_flag_r <= 1'b0;
      mask_r       <= '0;
    end else begin
      if (push_s && bus.proc_packet.is_rst_to_resume)    rst_flag_r <= 1'b1;
      else if (clr_rst_to_resume_in_pipeline_update)     rst_flag_r <= 1'b0;
      if (push_s && bus.proc_packet.is_flush_to_resume)  flush_flag_r <= 1'b1;
      else if (clr_flush_to_resume_in_pipeline_update)   flush_flag_r <= 1'b0;
      mask_r <= mask_next_s;
    end
  end

  assign rst_to_resume_in_pipeline   = rst_flag_r;
  assign flush_to_resume_in_pipeline = flush_flag_r;
  assign pending_table_mask          = mask_r;

endmodule
